// File: rtl/branch_resolve_cp4_if.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_cp4_if
// Brief   : Execute-stage branch resolution bus: instruction, comparator flags,
//           redirect/flush outputs and branch statistics counters.
// Revision: 1.0 - initial release
// ============================================================================
interface branch_resolve_cp4_if #(
   parameter int CNT_W = 32
);
   logic             ex_valid;
   logic             ex_is_branch;
   logic             ex_is_jal;
   logic             ex_is_jalr;
   logic [2:0]       ex_funct3;
   logic [31:0]      ex_pc;
   logic [31:0]      ex_imm;
   logic [31:0]      ex_rs1;
   logic             br_eq;
   logic             br_lt;
   logic             br_un;
   logic             stall;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             flush;
   logic             illegal_br;
   logic             misalign;
   logic             cnt_clr;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] taken_count;

   modport master (
      output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
             ex_pc, ex_imm, ex_rs1, br_eq, br_lt, stall, cnt_clr,
      input  br_un, redirect_valid, redirect_pc, flush, illegal_br,
             misalign, branch_count, taken_count
   );

   modport slave (
      input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
             ex_pc, ex_imm, ex_rs1, br_eq, br_lt, stall, cnt_clr,
      output br_un, redirect_valid, redirect_pc, flush, illegal_br,
             misalign, branch_count, taken_count
   );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_cp4.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_cp4
// Brief   : Resolves branches/JAL/JALR in execute, issues redirect + flush of
//           younger instructions, and keeps saturating branch statistics.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_cp4 #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  wire logic           clk,
   input  wire logic           rst,
   branch_resolve_cp4_if.slave bus
);
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_SQUASH = 1'b1
   } state_t;

   localparam logic [2:0]       c_flush_init = 3'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] c_cnt_max    = '1;
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_sq_cnt, w_sq_cnt_nxt;
   logic             r_redirect_valid;
   logic [31:0]      r_redirect_pc;
   logic             r_illegal_br;
   logic             r_misalign;
   logic [CNT_W-1:0] r_branch_count;
   logic [CNT_W-1:0] r_taken_count;

   logic             w_resolve;
   logic             w_kind_jal, w_kind_jalr, w_kind_br;
   logic             w_illegal, w_cond, w_taken;
   logic [31:0]      w_pc_sum, w_rs1_sum, w_target;
   logic             w_redirect, w_misalign, w_count_br;

   assign w_resolve   = (r_state == ST_IDLE) && bus.ex_valid && !bus.stall;

   // JAL wins over JALR, which wins over a conditional branch
   assign w_kind_jal  = bus.ex_is_jal;
   assign w_kind_jalr = !bus.ex_is_jal && bus.ex_is_jalr;
   assign w_kind_br   = !bus.ex_is_jal && !bus.ex_is_jalr && bus.ex_is_branch;
   assign w_illegal   = w_kind_br && (bus.ex_funct3[2:1] == 2'b01);

   always_comb begin
      w_cond = 1'b0;
      case (bus.ex_funct3)
         3'b000:         w_cond = bus.br_eq;
         3'b001:         w_cond = !bus.br_eq;
         3'b100, 3'b110: w_cond = bus.br_lt;
         3'b101, 3'b111: w_cond = !bus.br_lt;
         default:        w_cond = 1'b0;
      endcase
   end

   assign w_pc_sum   = bus.ex_pc + bus.ex_imm;
   assign w_rs1_sum  = bus.ex_rs1 + bus.ex_imm;
   assign w_target   = w_kind_jalr ? {w_rs1_sum[31:1], 1'b0} : w_pc_sum;
   assign w_taken    = w_kind_jal || w_kind_jalr || (w_kind_br && !w_illegal && w_cond);
   assign w_redirect = w_resolve && w_taken && !w_target[1];
   assign w_misalign = w_resolve && w_taken && w_target[1];
   assign w_count_br = w_resolve && w_kind_br && !w_illegal;

   assign bus.br_un          = bus.ex_funct3[1];
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.flush          = (r_state == ST_SQUASH);
   assign bus.illegal_br     = r_illegal_br;
   assign bus.misalign       = r_misalign;
   assign bus.branch_count   = r_branch_count;
   assign bus.taken_count    = r_taken_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_sq_cnt <= 3'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_sq_cnt <= w_sq_cnt_nxt;
      end
   end

   // Squash length counts down unconditionally; stall does not extend it
   always_comb begin
      w_state_nxt  = r_state;
      w_sq_cnt_nxt = r_sq_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_redirect) begin
               w_state_nxt  = ST_SQUASH;
               w_sq_cnt_nxt = c_flush_init;
            end
         end
         ST_SQUASH: begin
            w_sq_cnt_nxt = r_sq_cnt - 3'd1;
            if (r_sq_cnt == 3'd1) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
         r_illegal_br     <= 1'b0;
         r_misalign       <= 1'b0;
      end else begin
         r_redirect_valid <= w_redirect;
         r_illegal_br     <= w_resolve && w_illegal;
         r_misalign       <= w_misalign;
         if (w_redirect) r_redirect_pc <= w_target;
      end
   end

   // A misaligned taken branch is still a taken branch for statistics
   always_ff @(posedge clk) begin
      if (rst || bus.cnt_clr) begin
         r_branch_count <= '0;
         r_taken_count  <= '0;
      end else if (w_count_br) begin
         if (r_branch_count != c_cnt_max) r_branch_count <= r_branch_count + c_cnt_one;
         if (w_cond && (r_taken_count != c_cnt_max)) r_taken_count <= r_taken_count + c_cnt_one;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_cp4.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve_cp4
// Brief   : Self-checking bench: directed vector table, random stimulus against
//           a reference model, and hand sequences for reset/saturation cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_resolve_cp4;
   localparam int CNT_W = 4;
   localparam int FLUSH = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_resolve_cp4_if #(.CNT_W(CNT_W)) bus ();
   branch_resolve_cp4 #(.FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst, valid, br, jal, jalr;
      logic [2:0]  f3;
      logic [31:0] pc, imm, rs1;
      logic        eq, lt, stall, clr;
   } vin_t;

   typedef struct {
      vin_t        in;
      logic        rv;
      logic [31:0] rpc;
      logic        fl, ill, mis;
      int          bc, tc;
   } vec_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   vin_t cur;

   // reference model state: m_sq = flush cycles still owed, including this one
   int          m_sq, m_bc, m_tc;
   logic        m_rv, m_fl, m_ill, m_mis;
   logic [31:0] m_pc;

   function automatic vin_t mk(logic r, logic v, logic b, logic j, logic jr, logic [2:0] f3,
                               logic [31:0] pc, logic [31:0] imm, logic [31:0] rs1,
                               logic eq, logic lt, logic st, logic clr);
      vin_t x;
      x.rst = r; x.valid = v; x.br = b; x.jal = j; x.jalr = jr; x.f3 = f3;
      x.pc = pc; x.imm = imm; x.rs1 = rs1; x.eq = eq; x.lt = lt; x.stall = st; x.clr = clr;
      return x;
   endfunction

   function automatic vec_t vx(vin_t in, logic rv, logic [31:0] rpc, logic fl, logic ill,
                               logic mis, int bc, int tc);
      vec_t e;
      e.in = in; e.rv = rv; e.rpc = rpc; e.fl = fl; e.ill = ill; e.mis = mis; e.bc = bc; e.tc = tc;
      return e;
   endfunction

   function automatic vin_t nop();
      return mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input vin_t v);
      bit res, is_jal, is_jalr, is_br, ill, cond, tk;
      logic [31:0] tgt;
      if (v.rst) begin
         m_sq = 0; m_bc = 0; m_tc = 0; m_rv = 0; m_fl = 0; m_ill = 0; m_mis = 0; m_pc = 0;
      end else begin
         res     = (m_sq == 0) && v.valid && !v.stall;
         is_jal  = v.jal;
         is_jalr = !v.jal && v.jalr;
         is_br   = !v.jal && !v.jalr && v.br;
         ill     = is_br && (v.f3 == 3'b010 || v.f3 == 3'b011);
         case (v.f3)
            3'b000:  cond = v.eq;
            3'b001:  cond = !v.eq;
            3'b100:  cond = v.lt;
            3'b101:  cond = !v.lt;
            3'b110:  cond = v.lt;
            3'b111:  cond = !v.lt;
            default: cond = 0;
         endcase
         tgt   = is_jalr ? ((v.rs1 + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
         tk    = is_jal || is_jalr || (is_br && !ill && cond);
         m_rv  = res && tk && !tgt[1];
         m_ill = res && ill;
         m_mis = res && tk && tgt[1];
         if (m_rv) m_pc = tgt;
         if (m_sq > 0) m_sq--;
         else if (m_rv) m_sq = FLUSH;
         m_fl = (m_sq > 0);
         if (v.clr) begin
            m_bc = 0; m_tc = 0;
         end else if (res && is_br && !ill) begin
            m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
            if (cond) m_tc = (m_tc < CMAX) ? m_tc + 1 : CMAX;
         end
      end
   endtask

   task automatic apply(input vin_t v);
      rst              = v.rst;
      bus.ex_valid     = v.valid;
      bus.ex_is_branch = v.br;
      bus.ex_is_jal    = v.jal;
      bus.ex_is_jalr   = v.jalr;
      bus.ex_funct3    = v.f3;
      bus.ex_pc        = v.pc;
      bus.ex_imm       = v.imm;
      bus.ex_rs1       = v.rs1;
      bus.br_eq        = v.eq;
      bus.br_lt        = v.lt;
      bus.stall        = v.stall;
      bus.cnt_clr      = v.clr;
   endtask

   // inputs change on negedge, DUT samples on posedge, outputs read on next negedge
   task automatic cyc(input vin_t v);
      apply(v);
      cur = v;
      @(posedge clk);
      model_step(v);
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".redirect_valid"}, {31'd0, bus.redirect_valid}, {31'd0, m_rv});
      chk({tag, ".redirect_pc"}, bus.redirect_pc, m_pc);
      chk({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, m_fl});
      chk({tag, ".illegal_br"}, {31'd0, bus.illegal_br}, {31'd0, m_ill});
      chk({tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, m_mis});
      chk({tag, ".branch_count"}, 32'(bus.branch_count), 32'(m_bc));
      chk({tag, ".taken_count"}, 32'(bus.taken_count), 32'(m_tc));
      chk({tag, ".br_un"}, {31'd0, bus.br_un}, {31'd0, cur.f3[1]});
   endtask

   vec_t tbl[23];
   vin_t v;

   initial begin
      tbl[0]  = vx(mk(1,0,0,0,0,3'b000,0,0,0,0,0,0,0), 0, 32'h0, 0,0,0, 0,0);
      tbl[1]  = vx(mk(0,1,1,0,0,3'b000,32'h100,32'h20,0,1,0,0,0), 1, 32'h120, 1,0,0, 1,1);
      tbl[2]  = vx(mk(0,1,0,1,0,3'b000,32'h0,32'h40,0,0,0,0,0), 0, 32'h120, 1,0,0, 1,1);
      tbl[3]  = vx(mk(0,1,1,0,0,3'b000,32'h200,32'h8,0,1,0,0,0), 0, 32'h120, 0,0,0, 1,1);
      tbl[4]  = vx(mk(0,1,1,0,0,3'b111,32'h100,32'h20,0,0,1,0,0), 0, 32'h120, 0,0,0, 2,1);
      tbl[5]  = vx(mk(0,1,0,0,1,3'b000,0,0,32'h1003,0,0,0,0), 0, 32'h120, 0,0,1, 2,1);
      tbl[6]  = vx(mk(0,1,0,0,1,3'b000,0,0,32'h1001,0,0,0,0), 1, 32'h1000, 1,0,0, 2,1);
      tbl[7]  = vx(nop(), 0, 32'h1000, 1,0,0, 2,1);
      tbl[8]  = vx(nop(), 0, 32'h1000, 0,0,0, 2,1);
      tbl[9]  = vx(mk(0,1,1,0,0,3'b010,32'h100,32'h20,0,1,1,0,0), 0, 32'h1000, 0,1,0, 2,1);
      tbl[10] = vx(mk(0,1,1,0,0,3'b010,32'h100,32'h20,0,1,1,1,0), 0, 32'h1000, 0,0,0, 2,1);
      tbl[11] = vx(mk(0,1,0,1,0,3'b000,32'hFFFF_FFF0,32'h20,0,0,0,0,0), 1, 32'h10, 1,0,0, 2,1);
      tbl[12] = vx(nop(), 0, 32'h10, 1,0,0, 2,1);
      tbl[13] = vx(nop(), 0, 32'h10, 0,0,0, 2,1);
      tbl[14] = vx(mk(0,1,1,0,0,3'b001,32'h300,32'hFFFF_FFF0,0,0,0,0,0), 1, 32'h2F0, 1,0,0, 3,2);
      tbl[15] = vx(nop(), 0, 32'h2F0, 1,0,0, 3,2);
      tbl[16] = vx(nop(), 0, 32'h2F0, 0,0,0, 3,2);
      tbl[17] = vx(mk(0,1,1,0,0,3'b100,32'h400,32'h6,0,0,1,0,0), 0, 32'h2F0, 0,0,1, 4,3);
      tbl[18] = vx(mk(0,1,1,0,0,3'b110,32'h400,32'h8,0,0,0,0,0), 0, 32'h2F0, 0,0,0, 5,3);
      tbl[19] = vx(mk(0,1,0,0,0,3'b000,32'h100,32'h20,0,1,0,0,0), 0, 32'h2F0, 0,0,0, 5,3);
      tbl[20] = vx(mk(0,1,1,1,0,3'b010,32'h500,32'h10,0,0,0,0,0), 1, 32'h510, 1,0,0, 5,3);
      tbl[21] = vx(nop(), 0, 32'h510, 1,0,0, 5,3);
      tbl[22] = vx(nop(), 0, 32'h510, 0,0,0, 5,3);

      apply(mk(1,0,0,0,0,3'b000,0,0,0,0,0,0,0));
      @(negedge clk);

      for (int i = 0; i < 23; i++) begin
         cyc(tbl[i].in);
         chk($sformatf("tbl%0d.redirect_valid", i), {31'd0, bus.redirect_valid}, {31'd0, tbl[i].rv});
         chk($sformatf("tbl%0d.redirect_pc", i), bus.redirect_pc, tbl[i].rpc);
         chk($sformatf("tbl%0d.flush", i), {31'd0, bus.flush}, {31'd0, tbl[i].fl});
         chk($sformatf("tbl%0d.illegal_br", i), {31'd0, bus.illegal_br}, {31'd0, tbl[i].ill});
         chk($sformatf("tbl%0d.misalign", i), {31'd0, bus.misalign}, {31'd0, tbl[i].mis});
         chk($sformatf("tbl%0d.branch_count", i), 32'(bus.branch_count), 32'(tbl[i].bc));
         chk($sformatf("tbl%0d.taken_count", i), 32'(bus.taken_count), 32'(tbl[i].tc));
         chk($sformatf("tbl%0d.br_un", i), {31'd0, bus.br_un}, {31'd0, tbl[i].in.f3[1]});
      end

      // random stimulus against the reference model
      for (int i = 0; i < 600; i++) begin
         v       = nop();
         v.rst   = ($urandom_range(0, 99) < 2);
         v.valid = ($urandom_range(0, 9) < 7);
         v.br    = 1'($urandom_range(0, 1));
         v.jal   = ($urandom_range(0, 5) == 0);
         v.jalr  = ($urandom_range(0, 5) == 0);
         v.f3    = 3'($urandom_range(0, 7));
         v.pc    = $urandom;
         v.imm   = $urandom;
         v.rs1   = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            v.pc  = v.pc & 32'hFFFF_FFFC;
            v.imm = v.imm & 32'hFFFF_FFFC;
         end
         v.eq    = 1'($urandom_range(0, 1));
         v.lt    = 1'($urandom_range(0, 1));
         v.stall = ($urandom_range(0, 9) < 2);
         v.clr   = ($urandom_range(0, 99) < 4);
         cyc(v);
         chk_model($sformatf("rnd%0d", i));
      end

      // reset in the first SQUASH cycle aborts the flush; IDLE resolves at once
      cyc(mk(1,0,0,0,0,3'b000,0,0,0,0,0,0,0));
      cyc(mk(0,1,0,1,0,3'b000,32'h0,32'h40,0,0,0,0,0));
      chk_model("sqrst.jal");
      chk("sqrst.flush_on", {31'd0, bus.flush}, 32'd1);
      cyc(mk(1,0,0,0,0,3'b000,0,0,0,0,0,0,0));
      chk_model("sqrst.rst");
      chk("sqrst.flush_off", {31'd0, bus.flush}, 32'd0);
      cyc(mk(0,1,0,1,0,3'b000,32'h1000,32'h40,0,0,0,0,0));
      chk_model("sqrst.again");
      chk("sqrst.redirect", {31'd0, bus.redirect_valid}, 32'd1);
      chk("sqrst.pc", bus.redirect_pc, 32'h1040);
      cyc(nop());
      cyc(nop());

      // saturation of both counters
      for (int i = 0; i < 20; i++) begin
         cyc(mk(0,1,1,0,0,3'b000,32'h100,32'h20,0,1,0,0,0));
         cyc(nop());
         cyc(nop());
      end
      chk_model("sat");
      chk("sat.branch_count", 32'(bus.branch_count), 32'hF);
      chk("sat.taken_count", 32'(bus.taken_count), 32'hF);

      // clear wins over a same-cycle taken branch
      cyc(mk(0,1,1,0,0,3'b000,32'h100,32'h20,0,1,0,0,1));
      chk_model("clr");
      chk("clr.branch_count", 32'(bus.branch_count), 32'h0);
      chk("clr.taken_count", 32'(bus.taken_count), 32'h0);
      chk("clr.redirect", {31'd0, bus.redirect_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
